// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing the six-digit seven-segment display between three sources,
// with a minimum hold time. Optional source-0 preemption when SEG_ARB_PRIORITY_EN is defined.
module seg_display_arbiter #(
    parameter int TICK_CYCLES = 50_000,
    parameter int HOLD_MS     = 1000
) (
    input  logic        CLK_50M,
    input  logic        RST_N,
    input  logic [2:0]  i_req,
    input  logic [23:0] i_data0,
    input  logic [23:0] i_data1,
    input  logic [23:0] i_data2,
    input  logic [5:0]  i_dp0,
    input  logic [5:0]  i_dp1,
    input  logic [5:0]  i_dp2,
    output logic [2:0]  o_gnt,
    output logic [23:0] o_disp_data,
    output logic [5:0]  o_disp_dp,
    output logic        o_disp_valid
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int MW = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [MW-1:0] MS_DONE    = MW'(HOLD_MS);
    localparam logic [MW-1:0] MS_PENULT  = MW'(HOLD_MS - 1);

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q, last_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MW-1:0]   ms_q, ms_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [23:0]     data_q, data_d;
    logic [5:0]      dp_q, dp_d;
    logic            valid_q, valid_d;

    logic            take;
    logic [1:0]      new_owner;
    logic [2:0]      others;
    logic            expiring;
    logic            hold_yields;

    // First set bit of mask searching last+1, last+2, last+3 (mod 3).
    function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
        logic [1:0] pick;
        logic       found;
        int         s;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            s = (int'(last) + k) % 3;
            if (!found && mask[s]) begin
                found = 1'b1;
                pick  = 2'(s);
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        presc_d     = presc_q;
        ms_d        = ms_q;
        take        = 1'b0;
        new_owner   = owner_q;
        others      = i_req & ~(3'b001 << owner_q);
        // The edge that completes the hold counts as expired, so ownership lasts exactly the hold.
        expiring    = (ms_q == MS_DONE) || ((ms_q == MS_PENULT) && (presc_q == PRESC_LAST));
`ifdef SEG_ARB_PRIORITY_EN
        hold_yields = (owner_q != 2'd0);
`else
        hold_yields = 1'b1;
`endif

        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    take      = 1'b1;
                    new_owner = rr_pick(i_req, last_q);
                end
            end
            OWN: begin
                if (!i_req[owner_q]) begin
                    if (|i_req) begin
                        take      = 1'b1;
                        new_owner = rr_pick(i_req, last_q);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (expiring && hold_yields && (|others)) begin
                    take      = 1'b1;
                    new_owner = rr_pick(others, last_q);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SEG_ARB_PRIORITY_EN
        if (i_req[0] && !((state_q == OWN) && (owner_q == 2'd0))) begin
            take      = 1'b1;
            new_owner = 2'd0;
        end
`endif

        if (take) begin
            state_d = OWN;
            owner_d = new_owner;
            last_d  = new_owner;
            presc_d = '0;
            ms_d    = '0;
        end else if (state_d == IDLE) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (ms_q != MS_DONE) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                ms_d    = ms_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        if (state_d == OWN) begin
            gnt_d   = 3'b001 << owner_d;
            valid_d = 1'b1;
            case (owner_d)
                2'd0:    begin data_d = i_data0; dp_d = i_dp0; end
                2'd1:    begin data_d = i_data1; dp_d = i_dp1; end
                default: begin data_d = i_data2; dp_d = i_dp2; end
            endcase
        end else begin
            gnt_d   = 3'b000;
            valid_d = 1'b0;
            data_d  = 24'hFFFFFF;
            dp_d    = 6'b0;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            presc_q <= '0;
            ms_q    <= '0;
            gnt_q   <= 3'b000;
            data_q  <= 24'hFFFFFF;
            dp_q    <= 6'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
        end
    end

    assign o_gnt        = gnt_q;
    assign o_disp_data  = data_q;
    assign o_disp_dp    = dp_q;
    assign o_disp_valid = valid_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Table-driven scoreboard bench for seg_display_arbiter (TICK_CYCLES=4, HOLD_MS=3: 12-cycle hold).
module tb_seg_display_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  i_req;
    logic [23:0] i_data0, i_data1, i_data2;
    logic [5:0]  i_dp0, i_dp1, i_dp2;
    logic [2:0]  o_gnt;
    logic [23:0] o_disp_data;
    logic [5:0]  o_disp_dp;
    logic        o_disp_valid;

    typedef struct {
        logic [2:0] req;
        int         n;
        logic [2:0] gnt;
        string      tag;
    } vec_t;

    typedef struct {
        logic [2:0]  gnt;
        logic [23:0] data;
        logic [5:0]  dp;
        logic        valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    seg_display_arbiter #(.TICK_CYCLES(4), .HOLD_MS(3)) dut (
        .CLK_50M      (clk),
        .RST_N        (rst_n),
        .i_req        (i_req),
        .i_data0      (i_data0),
        .i_data1      (i_data1),
        .i_data2      (i_data2),
        .i_dp0        (i_dp0),
        .i_dp1        (i_dp1),
        .i_dp2        (i_dp2),
        .o_gnt        (o_gnt),
        .o_disp_data  (o_disp_data),
        .o_disp_dp    (o_disp_dp),
        .o_disp_valid (o_disp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input exp_t e, input string tag);
        checks++;
        if (o_gnt !== e.gnt || o_disp_data !== e.data || o_disp_dp !== e.dp || o_disp_valid !== e.valid) begin
            errors++;
            $display("FAIL %s got gnt=%b data=%h dp=%b valid=%b want gnt=%b data=%h dp=%b valid=%b",
                     tag, o_gnt, o_disp_data, o_disp_dp, o_disp_valid, e.gnt, e.data, e.dp, e.valid);
        end else begin
            $display("ok   %s gnt=%b data=%h dp=%b valid=%b", tag, o_gnt, o_disp_data, o_disp_dp, o_disp_valid);
        end
    endtask

    task automatic check_idle(input string tag);
        exp_t e;
        e.gnt = 3'b000; e.data = 24'hFFFFFF; e.dp = 6'b0; e.valid = 1'b0;
        compare(e, tag);
    endtask

    // Drive one cycle with fresh owner data, push the expectation, then pop and compare after the edge.
    task automatic run_cycle(input logic [2:0] req, input logic [2:0] gnt_exp, input string tag);
        exp_t e;
        @(negedge clk);
        i_req   = req;
        i_data0 = 24'($urandom);
        i_data1 = 24'($urandom);
        i_data2 = 24'($urandom);
        i_dp0   = 6'($urandom);
        i_dp1   = 6'($urandom);
        i_dp2   = 6'($urandom);
        e.gnt = gnt_exp;
        case (gnt_exp)
            3'b001:  begin e.data = i_data0; e.dp = i_dp0; e.valid = 1'b1; end
            3'b010:  begin e.data = i_data1; e.dp = i_dp1; e.valid = 1'b1; end
            3'b100:  begin e.data = i_data2; e.dp = i_dp2; e.valid = 1'b1; end
            default: begin e.data = 24'hFFFFFF; e.dp = 6'b0; e.valid = 1'b0; end
        endcase
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(sb.pop_front(), tag);
    endtask

    function automatic void add(input logic [2:0] req, input int n, input logic [2:0] gnt, input string tag);
        vec_t v;
        v.req = req; v.n = n; v.gnt = gnt; v.tag = tag;
        vecs.push_back(v);
    endfunction

    initial begin
        // first grant from reset, then 011 alternation with 12-cycle ownerships
        add(3'b111,  1, 3'b001, "first_grant");
        add(3'b011, 11, 3'b001, "rr_own0");
        add(3'b011, 12, 3'b010, "rr_own1");
        add(3'b011, 12, 3'b001, "rr_own0b");
        // owner 1 releases mid-hold; source 2 is next after last=1
        add(3'b011,  5, 3'b010, "own1_mid");
        add(3'b101, 12, 3'b100, "release_to2");
        add(3'b101,  1, 3'b001, "expire_to0");
        // single requester holds far beyond the hold, then drops
        add(3'b100, 40, 3'b100, "single2");
        add(3'b000,  3, 3'b000, "idle");
        // source 2 owns, source 0 arrives at cycle 3 of the hold
        add(3'b100,  3, 3'b100, "own2_pre");
`ifdef SEG_ARB_PRIORITY_EN
        add(3'b101,  1, 3'b001, "preempt0");
        add(3'b101, 20, 3'b001, "pri0_keep");
        add(3'b100,  1, 3'b100, "pri0_drop");
`else
        add(3'b101,  9, 3'b100, "own2_keep");
        add(3'b101, 12, 3'b001, "own0_after");
        add(3'b101,  1, 3'b100, "back_to2");
`endif
        // owner 2 releases, source 1 takes over just before the reset pulse
        add(3'b010,  5, 3'b010, "own1_pre_reset");

        rst_n   = 1'b0;
        i_req   = 3'b111;
        i_data0 = 24'h012345; i_data1 = 24'h6789AB; i_data2 = 24'hCDEF01;
        i_dp0   = 6'h01;      i_dp1   = 6'h02;      i_dp2   = 6'h04;
        repeat (3) @(negedge clk);
        check_idle("reset_values");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int v = 0; v < vecs.size(); v++) begin
            for (int c = 0; c < vecs[v].n; c++) begin
                run_cycle(vecs[v].req, vecs[v].gnt, vecs[v].tag);
            end
        end

        // asynchronous reset while source 1 owns mid-hold
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        @(posedge clk);
        #1;
        check_idle("reset_held");
        #2;
        rst_n = 1'b1;
        run_cycle(3'b011, 3'b001, "after_reset_src0");
        run_cycle(3'b011, 3'b001, "after_reset_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
